occupancy_lux_sensor: RTL and testbench
=======================================

# occupancy_lux_sensor

Sensor front-end for the room lighting path. It conditions the raw PIR motion input and the ambient-light ADC samples into the two clean status bits that the light controller consumes:
- `light`: 1 = daylight.
- `person`: 1 = room occupied.

It adds synchronisation, debounce, an occupancy hold timer and day/night hysteresis. It sits between the sensor pins/ADC and the light-control logic. Its outputs connect directly to that logic's light and person inputs.

## Interface
Parameters:
- `DEBOUNCE`, 4: consecutive synchronised PIR-high samples required to declare occupancy (≥1).
- `HOLD`, 16: consecutive synchronised PIR-low samples required to declare vacancy (≥1).
- `LUX_W`, 8: width of ADC sample.
- `NIGHT_TH`, 80: lux strictly below this counts as dark.
- `DAY_TH`, 120: lux strictly above this counts as bright. Must be > `NIGHT_TH`.
- `CONFIRM`, 3: consecutive qualifying valid samples needed to flip `light` (≥1).

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `pir_raw` in 1: asynchronous PIR motion input, 1 = motion.
- `lux` in `LUX_W`: ADC sample, unsigned. Qualified by `lux_valid`.
- `lux_valid` in 1: one-cycle strobe marking a new `lux` sample.
- `person` out 1: registered occupancy status. 1 = occupied.
- `light` out 1: registered ambient status. 1 = day, 0 = night.
- `occ_change` out 1: one-cycle pulse on the same edge that `person` changes value.

## Operation
- **PIR synchronisation:** `pir_raw` passes through a 2-flop synchroniser to give `pir_s`. Only `pir_s` feeds the FSM.
- **Occupancy FSM:** states VACANT, ARMING, OCCUPIED, HOLDING. Counter `cnt` is sized for max(`DEBOUNCE`, `HOLD`).
  - **VACANT** (`person`=0):
    - `pir_s`=1 → if `DEBOUNCE`=1, go to OCCUPIED. Otherwise go to ARMING with `cnt`=1.
  - **ARMING** (`person`=0):
    - `pir_s`=0 → VACANT, `cnt`=0.
    - `pir_s`=1 → `cnt`+1. When the count reaches `DEBOUNCE`, go to OCCUPIED.
  - **OCCUPIED** (`person`=1):
    - `pir_s`=0 → if `HOLD`=1, go to VACANT. Otherwise go to HOLDING with `cnt`=1.
  - **HOLDING** (`person`=1):
    - `pir_s`=1 → OCCUPIED. This retrigger needs no debounce and emits no `occ_change`.
    - `pir_s`=0 → `cnt`+1. When the count reaches `HOLD`, go to VACANT.
- **Occupancy change pulse:** `occ_change` = 1 for exactly the cycle following an edge where `person` toggled. It is never asserted for ARMING↔VACANT or HOLDING↔OCCUPIED transitions.
- **Day/night hysteresis:** runs only on cycles with `lux_valid`=1. Confirm counter `lcnt` is `$clog2(CONFIRM+1)` bits.
  - `light`=1 and `lux` < `NIGHT_TH` → `lcnt`+1.
  - `light`=0 and `lux` > `DAY_TH` → `lcnt`+1.
  - Any other valid sample, including values equal to a threshold, clears `lcnt`.
  - When `lcnt` would reach `CONFIRM`, `light` toggles and `lcnt` clears.
  - `lux_valid`=0 leaves `lcnt` and `light` unchanged. Invalid cycles do not break a run.
- **Independence:** the occupancy and ambient paths are independent. Simultaneous events on both are each handled in the same cycle.

## Timing
- **Reset values:** while `rst_n`=0, all state clears immediately without waiting for a clock edge:
  - sync flops 0, FSM = VACANT, `cnt`=0, `lcnt`=0
  - `person`=0, `occ_change`=0
  - `light`=1 (day, so lamp off until dark is confirmed)
- **Reset mid-operation:** asserting `rst_n` mid-operation (ARMING, HOLDING, partial `lcnt`) aborts it with no pulse emitted.
- **Occupancy latency:** `pir_raw` rises before edge E0 and holds. `person`=1 after edge E0+`DEBOUNCE`+1 (E0+5 at defaults), and `occ_change`=1 for that following cycle.
- **Vacancy latency:** `pir_s` first sampled 0 at edge F. `person`=0 after edge F+`HOLD`−1, absent retrigger.
- **Ambient latency:** `light` toggles on the edge of the `CONFIRM`-th consecutive qualifying valid sample. No added latency.
- **Glitch rejection:** a `pir_raw` pulse shorter than `DEBOUNCE` cycles never produces occupancy.

## Test plan
1. **Reset:** hold `rst_n`=0, toggle inputs → `person`=0, `light`=1, `occ_change`=0. Release with `pir_raw`=0 and no `lux_valid` → outputs unchanged for 50 cycles.
2. **PIR debounce:** `pir_raw` high for 3 cycles → `person` stays 0. Then high from edge E0 onward → `person`=1 after E0+5, with exactly one `occ_change` pulse.
3. **PIR hold and retrigger:**
   - While occupied, drop `pir_raw` for 10 cycles then raise it → `person` stays 1, no `occ_change`.
   - Drop it again permanently → `person`=0 after F+15, with one `occ_change` pulse.
4. **Dark confirmation:** from `light`=1, valid samples 79, 79, 80, 79, 79, 79 → the sample equal to 80 clears `lcnt`. `light`=0 on the edge of the last 79.
5. **Bright confirmation with gaps:** from `light`=0, valid samples 121, 121, 121 separated by 5 idle cycles each → `light`=1 on the third. A sample of 120 (equal to `DAY_TH`) mid-run restarts the count.
6. **Async reset mid-operation:** assert `rst_n` between edges while in HOLDING with `lcnt`=2 → `person`=0 and `light`=1 before the next edge. After release, a fresh debounce (E0+5) is required.

Source files
------------

// File: rtl/occupancy_lux_sensor.sv
// occupancy_lux_sensor
// Sensor front-end for the lighting path: synchronises and debounces the PIR
// input into an occupancy status with a hold timer, and turns ambient-light
// ADC samples into a day/night status with hysteresis and run confirmation.

module occupancy_lux_sensor #(
   parameter int DEBOUNCE = 4,
   parameter int HOLD     = 16,
   parameter int LUX_W    = 8,
   parameter int NIGHT_TH = 80,
   parameter int DAY_TH   = 120,
   parameter int CONFIRM  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pir_raw,
   input  logic [LUX_W-1:0] lux,
   input  logic             lux_valid,
   output logic             person,
   output logic             light,
   output logic             occ_change
);

   // Shared counter must cover the longer of the debounce and hold runs.
   localparam int CNT_MAX = (DEBOUNCE > HOLD) ? DEBOUNCE : HOLD;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int LCNT_W  = $clog2(CONFIRM + 1);

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE);
   localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD);
   localparam logic [LCNT_W-1:0] LCNT_ZERO = {LCNT_W{1'b0}};
   localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);
   localparam logic [LCNT_W-1:0] CONF_LAST = LCNT_W'(CONFIRM);
   localparam logic [LUX_W-1:0]  NIGHT_LUX = LUX_W'(NIGHT_TH);
   localparam logic [LUX_W-1:0]  DAY_LUX   = LUX_W'(DAY_TH);

   typedef enum logic [1:0] {
      VACANT   = 2'd0,
      ARMING   = 2'd1,
      OCCUPIED = 2'd2,
      HOLDING  = 2'd3
   } occ_state_t;

   logic              sync_meta_r;
   logic              pir_s_r;
   occ_state_t        state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic [LCNT_W-1:0] lcnt_r;
   logic [LCNT_W-1:0] lcnt_inc_s;
   logic              lux_qual_s;

   assign cnt_inc_s  = cnt_r + CNT_ONE;
   assign lcnt_inc_s = lcnt_r + LCNT_ONE;

   // Two-flop synchroniser bringing the asynchronous PIR pin into clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta_r <= 1'b0;
         pir_s_r     <= 1'b0;
      end else begin
         sync_meta_r <= pir_raw;
         pir_s_r     <= sync_meta_r;
      end
   end

   // Occupancy FSM: debounce on entry, hold timer on exit, registered status and change pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= VACANT;
         cnt_r      <= CNT_ZERO;
         person     <= 1'b0;
         occ_change <= 1'b0;
      end else begin
         occ_change <= 1'b0;
         case (state_r)
            VACANT: begin
               if (pir_s_r) begin
                  if (DEBOUNCE == 1) begin
                     state_r    <= OCCUPIED;
                     cnt_r      <= CNT_ZERO;
                     person     <= 1'b1;
                     occ_change <= 1'b1;
                  end else begin
                     state_r <= ARMING;
                     cnt_r   <= CNT_ONE;
                  end
               end else begin
                  cnt_r <= CNT_ZERO;
               end
            end
            ARMING: begin
               if (!pir_s_r) begin
                  state_r <= VACANT;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_inc_s == DEB_LAST) begin
                  state_r    <= OCCUPIED;
                  cnt_r      <= CNT_ZERO;
                  person     <= 1'b1;
                  occ_change <= 1'b1;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            OCCUPIED: begin
               if (!pir_s_r) begin
                  if (HOLD == 1) begin
                     state_r    <= VACANT;
                     cnt_r      <= CNT_ZERO;
                     person     <= 1'b0;
                     occ_change <= 1'b1;
                  end else begin
                     state_r <= HOLDING;
                     cnt_r   <= CNT_ONE;
                  end
               end else begin
                  cnt_r <= CNT_ZERO;
               end
            end
            HOLDING: begin
               // A retrigger simply resumes occupancy; person never dropped, so no pulse.
               if (pir_s_r) begin
                  state_r <= OCCUPIED;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_inc_s == HOLD_LAST) begin
                  state_r    <= VACANT;
                  cnt_r      <= CNT_ZERO;
                  person     <= 1'b0;
                  occ_change <= 1'b1;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            default: begin
               state_r <= VACANT;
               cnt_r   <= CNT_ZERO;
               person  <= 1'b0;
            end
         endcase
      end
   end

   // A sample qualifies only if it lies strictly beyond the threshold opposite the current status.
   always_comb begin
      lux_qual_s = 1'b0;
      if (light) begin
         lux_qual_s = (lux < NIGHT_LUX);
      end else begin
         lux_qual_s = (lux > DAY_LUX);
      end
   end

   // Day/night hysteresis: count consecutive qualifying valid samples, flip status on the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lcnt_r <= LCNT_ZERO;
         light  <= 1'b1;
      end else if (lux_valid) begin
         if (lux_qual_s) begin
            if (lcnt_inc_s == CONF_LAST) begin
               light  <= ~light;
               lcnt_r <= LCNT_ZERO;
            end else begin
               lcnt_r <= lcnt_inc_s;
            end
         end else begin
            lcnt_r <= LCNT_ZERO;
         end
      end else begin
         lcnt_r <= lcnt_r;
         light  <= light;
      end
   end

endmodule

// File: tb/tb_occupancy_lux_sensor.sv
// Self-checking bench for occupancy_lux_sensor at default parameters.
// Light hysteresis is driven from a vector table; occupancy and reset corner
// cases use hand-written cycle sequences with hand-computed expectations.

module tb_occupancy_lux_sensor;

   logic       clk;
   logic       rst_n;
   logic       pir_raw;
   logic [7:0] lux;
   logic       lux_valid;
   logic       person;
   logic       light;
   logic       occ_change;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       valid;
      logic [7:0] lux;
      logic       exp_light;
   } lvec_t;

   lvec_t tbl[$];

   occupancy_lux_sensor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pir_raw    (pir_raw),
      .lux        (lux),
      .lux_valid  (lux_valid),
      .person     (person),
      .light      (light),
      .occ_change (occ_change)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past one rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compare {person, occ_change, light} against expectation.
   task automatic check(input string name, input logic ep, input logic eo, input logic el);
      checks++;
      if ({person, occ_change, light} !== {ep, eo, el}) begin
         errors++;
         $display("FAIL %s @%0t: person/occ_change/light got %b%b%b expected %b%b%b",
                  name, $time, person, occ_change, light, ep, eo, el);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] l, input logic e);
      lvec_t r;
      r.valid = v;
      r.lux = l;
      r.exp_light = e;
      tbl.push_back(r);
   endtask

   initial begin
      // Light vector table: each record is one cycle, expectation after its edge.
      // Dark confirm: 80 is not below NIGHT_TH and breaks the run.
      add(1'b1, 8'd79, 1'b1);
      add(1'b1, 8'd79, 1'b1);
      add(1'b1, 8'd80, 1'b1);
      add(1'b1, 8'd79, 1'b1);
      add(1'b1, 8'd79, 1'b1);
      add(1'b1, 8'd79, 1'b0);
      // Bright confirm with 5-cycle gaps; invalid bright values are ignored.
      add(1'b1, 8'd121, 1'b0);
      for (int i = 0; i < 5; i++) add(1'b0, 8'd200, 1'b0);
      add(1'b1, 8'd121, 1'b0);
      for (int i = 0; i < 5; i++) add(1'b0, 8'd0, 1'b0);
      add(1'b1, 8'd121, 1'b1);
      // Back to dark, invalid dark value in a gap does not count.
      add(1'b1, 8'd79, 1'b1);
      add(1'b0, 8'd0, 1'b1);
      add(1'b1, 8'd78, 1'b1);
      add(1'b1, 8'd0, 1'b0);
      // 120 equals DAY_TH and restarts the bright run.
      add(1'b1, 8'd121, 1'b0);
      add(1'b1, 8'd120, 1'b0);
      add(1'b1, 8'd121, 1'b0);
      add(1'b1, 8'd121, 1'b0);
      add(1'b1, 8'd255, 1'b1);
      // In day, bright and mid-band samples clear a dark run.
      add(1'b1, 8'd200, 1'b1);
      add(1'b1, 8'd79, 1'b1);
      add(1'b1, 8'd120, 1'b1);
      add(1'b1, 8'd79, 1'b1);
      add(1'b1, 8'd79, 1'b1);
      add(1'b1, 8'd79, 1'b0);
      // Return to day for the reset test.
      add(1'b1, 8'd121, 1'b0);
      add(1'b1, 8'd121, 1'b0);
      add(1'b1, 8'd121, 1'b1);

      // ---------------- Reset ----------------
      rst_n     = 1'b1;
      pir_raw   = 1'b0;
      lux_valid = 1'b0;
      lux       = 8'd0;
      #2 rst_n = 1'b0;
      #1 check("reset_async", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         pir_raw   = ~pir_raw;
         lux_valid = 1'b1;
         lux       = 8'd10;
         step();
         check("reset_hold", 1'b0, 1'b0, 1'b1);
      end
      pir_raw   = 1'b0;
      lux_valid = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         check("idle_after_reset", 1'b0, 1'b0, 1'b1);
      end

      // ---------------- Glitch rejection ----------------
      pir_raw = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("glitch_high", 1'b0, 1'b0, 1'b1);
      end
      pir_raw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("glitch_low", 1'b0, 1'b0, 1'b1);
      end

      // ---------------- Debounce latency: person after E0+5 ----------------
      pir_raw = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         check("debounce", (i >= 5), (i == 5), 1'b1);
      end

      // ---------------- Hold with retrigger ----------------
      pir_raw = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i == 10) pir_raw = 1'b1;
         step();
         check("retrigger", 1'b1, 1'b0, 1'b1);
      end

      // ---------------- Vacancy: pir_s low at F=G+2, person 0 after F+15 ----------------
      pir_raw = 1'b0;
      for (int i = 0; i < 22; i++) begin
         step();
         check("vacancy", (i < 17), (i == 17), 1'b1);
      end

      // ---------------- Light hysteresis table ----------------
      foreach (tbl[k]) begin
         lux_valid = tbl[k].valid;
         lux       = tbl[k].lux;
         step();
         check($sformatf("lux_vec%0d", k), 1'b0, 1'b0, tbl[k].exp_light);
      end
      lux_valid = 1'b0;
      lux       = 8'd0;

      // ---------------- Async reset mid-operation ----------------
      pir_raw = 1'b1;
      for (int i = 0; i < 12; i++) step();
      check("reoccupy", 1'b1, 1'b0, 1'b1);
      pir_raw   = 1'b0;
      lux_valid = 1'b1;
      lux       = 8'd79;
      step();
      step();
      lux_valid = 1'b0;
      for (int i = 0; i < 3; i++) step();
      check("holding_pre_reset", 1'b1, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      pir_raw = 1'b1;
      #1 check("mid_reset_async", 1'b0, 1'b0, 1'b1);
      step();
      check("mid_reset_edge", 1'b0, 1'b0, 1'b1);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("post_reset_debounce", (i >= 5), (i == 5), 1'b1);
      end
      // lcnt was 2 before reset; it must need a full run of 3 again.
      lux_valid = 1'b1;
      lux       = 8'd79;
      step();
      check("post_reset_lcnt1", 1'b1, 1'b0, 1'b1);
      step();
      check("post_reset_lcnt2", 1'b1, 1'b0, 1'b1);
      step();
      check("post_reset_dark", 1'b1, 1'b0, 1'b0);
      lux_valid = 1'b0;
      step();
      check("post_reset_stable", 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
